// File: rtl/riscv_dbus_master.sv
// riscv_dbus_master
// MEM-stage data-bus master. Converts the load/store held in the M pipeline
// register into a req/gnt/rvalid bus transaction. While the transaction is
// outstanding it holds bus_stallM high. It returns load data that is
// lane-aligned and then sign- or zero-extended.
//
// Optional build macro: DBUS_TIMEOUT_EN enables a watchdog. The watchdog
// aborts a REQ+WAIT phase that lasts TIMEOUT cycles. The abort reports a bus
// error and zero data.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   i_mem_req         M-stage instruction is a load or store
//   i_mem_we          1 = store, 0 = load
//   i_mem_addr        byte address
//   i_mem_wdata       right-aligned store data
//   i_mem_size        00 byte, 01 half, 10 word, 11 illegal
//   i_mem_unsigned    zero-extend load data
//   bus_stallM        freezes F..M while the access is in progress
//   o_rdata           extended load data (zero outside a load DONE)
//   o_rdata_valid     one-cycle pulse in DONE for loads
//   o_misaligned      combinational: requested access is misaligned/illegal
//   o_bus_err         one-cycle pulse in DONE on bus error or timeout
//   o_bus_req/we/addr/be/wdata   bus request side (word address, registered)
//   i_bus_gnt, i_bus_rvalid, i_bus_err, i_bus_rdata   bus response side
module riscv_dbus_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_mem_req,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_addr,
  input  logic [31:0] i_mem_wdata,
  input  logic [1:0]  i_mem_size,
  input  logic        i_mem_unsigned,
  output logic        bus_stallM,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_misaligned,
  output logic        o_bus_err,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic        i_bus_err,
  input  logic [31:0] i_bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        bad_access;
  logic        start;
  logic        timeout;

  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [1:0]  req_off;
  logic        rsp_err;
  logic [31:0] rsp_data;

  function automatic logic [3:0] be_of(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lanes_of(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  // Bring the addressed lane down to bit 0, then extend it from its own MSB
  // unless the load is unsigned.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                              input logic [1:0] size, input logic uns);
    logic [31:0] lane;
    logic [31:0] result;
    lane = word >> {off, 3'b000};
    case (size)
      2'b00:   result = {{24{~uns & lane[7]}}, lane[7:0]};
      2'b01:   result = {{16{~uns & lane[15]}}, lane[15:0]};
      default: result = lane;
    endcase
    return result;
  endfunction

  always_comb begin
    bad_access = 1'b0;
    case (i_mem_size)
      2'b00:   bad_access = 1'b0;
      2'b01:   bad_access = i_mem_addr[0];
      2'b10:   bad_access = |i_mem_addr[1:0];
      default: bad_access = 1'b1;
    endcase
  end

  assign o_misaligned = i_mem_req & bad_access;
  assign start        = (state == IDLE) & i_mem_req & ~bad_access;

`ifdef DBUS_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (start) begin
      tmo_cnt <= 8'd0;
    end else if (state == REQ || state == WAIT) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  // The count reaches TIMEOUT at the edge that ends the TIMEOUT-th REQ/WAIT
  // cycle. The abort therefore fires while the count still holds TIMEOUT-1.
  assign timeout = (state == REQ || state == WAIT) && (tmo_cnt == 8'(TIMEOUT - 1));
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT);
  assign timeout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = REQ;
      REQ: begin
        if (timeout)        state_nxt = DONE;
        else if (i_bus_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (timeout || i_bus_rvalid) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture (IDLE -> REQ) and response capture (WAIT -> DONE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_we       <= 1'b0;
      req_addr     <= 32'd0;
      req_be       <= 4'd0;
      req_wdata    <= 32'd0;
      req_size     <= 2'd0;
      req_unsigned <= 1'b0;
      req_off      <= 2'd0;
      rsp_err      <= 1'b0;
      rsp_data     <= 32'd0;
    end else begin
      if (start) begin
        req_we       <= i_mem_we;
        req_addr     <= {i_mem_addr[31:2], 2'b00};
        req_be       <= be_of(i_mem_size, i_mem_addr[1:0]);
        req_wdata    <= lanes_of(i_mem_size, i_mem_wdata);
        req_size     <= i_mem_size;
        req_unsigned <= i_mem_unsigned;
        req_off      <= i_mem_addr[1:0];
      end
      if (timeout) begin
        rsp_err  <= 1'b1;
        rsp_data <= 32'd0;
      end else if (state == WAIT && i_bus_rvalid) begin
        rsp_err  <= i_bus_err;
        rsp_data <= i_bus_err ? 32'd0 : load_extend(i_bus_rdata, req_off, req_size, req_unsigned);
      end
    end
  end

  // o_bus_req decodes the state register directly, so it drops as soon as
  // reset is asserted.
  assign o_bus_req     = (state == REQ);
  assign o_bus_we      = req_we;
  assign o_bus_addr    = req_addr;
  assign o_bus_be      = req_be;
  assign o_bus_wdata   = req_wdata;
  assign bus_stallM    = start | (state == REQ) | (state == WAIT);
  assign o_rdata_valid = (state == DONE) & ~req_we;
  assign o_bus_err     = (state == DONE) & rsp_err;
  assign o_rdata       = o_rdata_valid ? rsp_data : 32'd0;

endmodule

// File: tb/tb_riscv_dbus_master.sv
module tb_riscv_dbus_master;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_mem_req = 1'b0;
  logic        i_mem_we = 1'b0;
  logic [31:0] i_mem_addr = 32'd0;
  logic [31:0] i_mem_wdata = 32'd0;
  logic [1:0]  i_mem_size = 2'd2;
  logic        i_mem_unsigned = 1'b0;
  logic        bus_stallM;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_misaligned;
  logic        o_bus_err;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_be;
  logic [31:0] o_bus_wdata;
  logic        i_bus_gnt = 1'b0;
  logic        i_bus_rvalid = 1'b0;
  logic        i_bus_err = 1'b0;
  logic [31:0] i_bus_rdata = 32'd0;

  always #5 clk = ~clk;

  riscv_dbus_master #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .i_mem_size(i_mem_size), .i_mem_unsigned(i_mem_unsigned),
    .bus_stallM(bus_stallM), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
    .o_bus_wdata(o_bus_wdata), .i_bus_gnt(i_bus_gnt), .i_bus_rvalid(i_bus_rvalid),
    .i_bus_err(i_bus_err), .i_bus_rdata(i_bus_rdata)
  );

  int nvec = 0;
  int nerr = 0;

  // Expected outputs for the current cycle, set by the driver.
  logic        chk_en = 1'b0;
  logic        e_stall = 1'b0, e_req = 1'b0, e_valid = 1'b0, e_err = 1'b0, e_mis = 1'b0;
  logic [31:0] e_rdata = 32'd0;
  logic        e_bus = 1'b0, e_we = 1'b0;
  logic [31:0] e_addr = 32'd0, e_wdata = 32'd0;
  logic [3:0]  e_be = 4'd0;

  // Observations used by the literal checks of the directed cases.
  int          stall_cnt = 0, req_cnt = 0, valid_cnt = 0;
  logic [31:0] cap_rdata = 32'd0, cap_addr = 32'd0, cap_wdata = 32'd0;
  logic [3:0]  cap_be = 4'd0;
  logic        cap_we = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic mdl_mis(input logic [31:0] a, input logic [1:0] sz);
    int off;
    off = int'(a[1:0]);
    return (sz == 2'd3) || (sz == 2'd1 && (off % 2) != 0) || (sz == 2'd2 && off != 0);
  endfunction

  function automatic logic [3:0] mdl_be(input logic [31:0] a, input logic [1:0] sz);
    int off;
    off = int'(a[1:0]);
    if (sz == 2'd0) return 4'(1 << off);
    if (sz == 2'd1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] mdl_wdata(input logic [31:0] w, input logic [1:0] sz);
    if (sz == 2'd0) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] mdl_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    longint v;
    int off;
    off = int'(a[1:0]);
    v = longint'(rd >> (8 * off));
    if (sz == 2'd0) begin
      v = v & 'hFF;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = v & 'hFFFF;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return 32'(v);
  endfunction

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(bus_stallM), 32'(e_stall));
      chk("bus_req", 32'(o_bus_req), 32'(e_req));
      chk("rdata_valid", 32'(o_rdata_valid), 32'(e_valid));
      chk("bus_err", 32'(o_bus_err), 32'(e_err));
      chk("misaligned", 32'(o_misaligned), 32'(e_mis));
      chk("rdata", o_rdata, e_rdata);
      if (e_bus) begin
        chk("bus_we", 32'(o_bus_we), 32'(e_we));
        chk("bus_addr", o_bus_addr, e_addr);
        chk("bus_be", 32'(o_bus_be), 32'(e_be));
        chk("bus_wdata", o_bus_wdata, e_wdata);
      end
      if (bus_stallM) stall_cnt++;
      if (o_bus_req) begin
        req_cnt++;
        cap_addr  = o_bus_addr;
        cap_be    = o_bus_be;
        cap_wdata = o_bus_wdata;
        cap_we    = o_bus_we;
      end
      if (o_rdata_valid) begin
        valid_cnt++;
        cap_rdata = o_rdata;
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic set_exp_zero();
    e_stall = 1'b0; e_req = 1'b0; e_valid = 1'b0; e_err = 1'b0; e_mis = 1'b0;
    e_rdata = 32'd0; e_bus = 1'b0;
  endtask

  task automatic drive_mem(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [1:0] sz, input logic uns);
    i_mem_req = 1'b1; i_mem_we = we; i_mem_addr = addr;
    i_mem_wdata = wd; i_mem_size = sz; i_mem_unsigned = uns;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_stall"}, 32'(bus_stallM), 32'd0);
    chk({tag, "_req"}, 32'(o_bus_req), 32'd0);
    chk({tag, "_valid"}, 32'(o_rdata_valid), 32'd0);
    chk({tag, "_err"}, 32'(o_bus_err), 32'd0);
    chk({tag, "_rdata"}, o_rdata, 32'd0);
    chk({tag, "_addr"}, o_bus_addr, 32'd0);
    chk({tag, "_be"}, 32'(o_bus_be), 32'd0);
    chk({tag, "_wdata"}, o_bus_wdata, 32'd0);
    chk({tag, "_we"}, 32'(o_bus_we), 32'd0);
  endtask

  task automatic do_reset();
    chk_en = 1'b0;
    rst_n = 1'b0;
    i_mem_req = 1'b0; i_bus_gnt = 1'b0; i_bus_rvalid = 1'b0; i_bus_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    #2 rst_n = 1'b1;
    set_exp_zero();
    chk_en = 1'b1;
  endtask

  task automatic drive_idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_mem_req = 1'b0; i_mem_we = 1'($urandom); i_mem_addr = $urandom & 32'hFFFF_FFFC;
      i_mem_size = 2'd2; i_mem_wdata = $urandom; i_mem_unsigned = 1'($urandom);
      i_bus_gnt = 1'($urandom); i_bus_rvalid = 1'($urandom);
      i_bus_err = 1'($urandom); i_bus_rdata = $urandom;
      set_exp_zero();
    end
  endtask

  // One access: g cycles without grant before the granting cycle, r cycles
  // without rvalid before the responding cycle. Spurious gnt/rvalid pulses are
  // sprinkled where they must be ignored.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [1:0] sz, input logic uns, input int g, input int r,
                     input logic [31:0] rd, input logic berr);
    int total;
    logic [31:0] ld;
    ld = mdl_load(rd, addr, sz, uns);
    if (mdl_mis(addr, sz)) begin
      @(posedge clk); #1;
      drive_mem(we, addr, wd, sz, uns);
      i_bus_gnt = 1'($urandom); i_bus_rvalid = 1'($urandom); i_bus_rdata = $urandom;
      set_exp_zero();
      e_mis = 1'b1;
      return;
    end
    total = 3 + g + r;
    for (int k = 0; k <= total; k++) begin
      @(posedge clk); #1;
      drive_mem(we, addr, wd, sz, uns);
      i_bus_gnt    = (k == 1 + g) || (k > 1 + g && 1'($urandom));
      i_bus_rvalid = (k == 2 + g + r) || ((k < 2 + g || k > 2 + g + r) && 1'($urandom));
      i_bus_err    = (k == 2 + g + r) ? berr : 1'($urandom);
      i_bus_rdata  = (k == 2 + g + r) ? rd : $urandom;
      e_stall = (k < total);
      e_req   = (k >= 1 && k <= 1 + g);
      e_bus   = e_req;
      e_we    = we;
      e_addr  = addr & 32'hFFFF_FFFC;
      e_be    = mdl_be(addr, sz);
      e_wdata = mdl_wdata(wd, sz);
      e_mis   = 1'b0;
      e_valid = (k == total) && !we;
      e_err   = (k == total) && berr;
      e_rdata = ((k == total) && !we && !berr) ? ld : 32'd0;
    end
  endtask

  task automatic clear_obs();
    stall_cnt = 0; req_cnt = 0; valid_cnt = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [1:0]  sz;
    logic [31:0] addr;

    do_reset();
    drive_idle(2);

    // Word load, best case.
    clear_obs();
    txn(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0);
    drive_idle(1);
    chk("ldw_stall_cycles", 32'(stall_cnt), 32'd3);
    chk("ldw_rdata", cap_rdata, 32'hDEADBEEF);
    chk("ldw_valid_pulses", 32'(valid_cnt), 32'd1);

    // Signed / unsigned byte load from the top lane.
    txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 0, 0, 32'h80123456, 1'b0);
    drive_idle(1);
    chk("ldb_be", 32'(cap_be), 32'h8);
    chk("ldb_signed", cap_rdata, 32'hFFFFFF80);
    txn(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 1, 1, 32'h80123456, 1'b0);
    drive_idle(1);
    chk("ldb_unsigned", cap_rdata, 32'h00000080);

    // Half store with a late grant.
    clear_obs();
    txn(1'b1, 32'h102, 32'h00001234, 2'd1, 1'b0, 3, 0, 32'h0, 1'b0);
    drive_idle(1);
    chk("sth_req_cycles", 32'(req_cnt), 32'd4);
    chk("sth_addr", cap_addr, 32'h100);
    chk("sth_be", 32'(cap_be), 32'hC);
    chk("sth_wdata", cap_wdata, 32'h12341234);
    chk("sth_we", 32'(cap_we), 32'd1);
    chk("sth_no_valid", 32'(valid_cnt), 32'd0);

    // Misaligned word load.
    txn(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 0, 0, 32'h0, 1'b0);
    #1;
    chk("mis_flag", 32'(o_misaligned), 32'd1);
    chk("mis_req", 32'(o_bus_req), 32'd0);
    chk("mis_stall", 32'(bus_stallM), 32'd0);
    drive_idle(1);

    // Load answered with a bus error.
    txn(1'b0, 32'h204, 32'h0, 2'd2, 1'b0, 1, 2, 32'h12345678, 1'b1);
    drive_idle(1);

    // Grant never arrives.
`ifdef DBUS_TIMEOUT_EN
    for (int k = 0; k <= TO + 1; k++) begin
      @(posedge clk); #1;
      drive_mem(1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'($urandom); i_bus_rdata = $urandom;
      e_stall = (k <= TO);
      e_req   = (k >= 1 && k <= TO);
      e_bus   = e_req; e_we = 1'b0; e_addr = 32'h200; e_be = 4'hF; e_wdata = 32'h0;
      e_mis   = 1'b0;
      e_valid = (k == TO + 1);
      e_err   = (k == TO + 1);
      e_rdata = 32'd0;
    end
    drive_idle(2);
`else
    for (int k = 0; k <= 20; k++) begin
      @(posedge clk); #1;
      drive_mem(1'b0, 32'h200, 32'h0, 2'd2, 1'b0);
      i_bus_gnt = 1'b0; i_bus_rvalid = 1'($urandom); i_bus_rdata = $urandom;
      set_exp_zero();
      e_stall = 1'b1;
      e_req   = (k >= 1);
    end
    do_reset();
    drive_idle(1);
`endif

    // Reset pulsed during WAIT, then a stale rvalid.
    for (int k = 0; k <= 2; k++) begin
      @(posedge clk); #1;
      drive_mem(1'b0, 32'h300, 32'h0, 2'd2, 1'b0);
      i_bus_gnt = (k == 1); i_bus_rvalid = 1'b0; i_bus_rdata = $urandom;
      set_exp_zero();
      e_stall = 1'b1;
      e_req   = (k == 1);
    end
    #2;
    chk_en = 1'b0;
    rst_n = 1'b0;
    i_mem_req = 1'b0;
    #1;
    check_zero("midrst");
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    i_mem_req = 1'b0; i_bus_rvalid = 1'b1; i_bus_err = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
    set_exp_zero();
    e_bus = 1'b1; e_we = 1'b0; e_addr = 32'd0; e_be = 4'd0; e_wdata = 32'd0;
    chk_en = 1'b1;
    drive_idle(1);
    txn(1'b0, 32'h302, 32'h0, 2'd1, 1'b0, 0, 1, 32'h9ABC0000, 1'b0);
    drive_idle(1);

    // Randomised traffic, including back-to-back accesses.
    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 2));
      if ($urandom % 10 == 0) sz = 2'd3;
      addr = $urandom;
      if ($urandom % 4 != 0) begin
        if (sz == 2'd1) addr[0] = 1'b0;
        if (sz == 2'd2) addr[1:0] = 2'b00;
      end
      txn(1'($urandom), addr, $urandom, sz, 1'($urandom),
          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), $urandom, ($urandom % 8) == 0);
      drive_idle(int'($urandom_range(0, 2)));
    end
    drive_idle(2);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
